// File: rtl/srdl2sv_b2r.sv
// srdl2sv_b2r_decoder
//   Address decoder / response mux between a bus-protocol widget (b2r/r2b)
//   and N_REGIONS register blocks. The widget sees one response per access:
//   from the selected region, an unmapped error, or (optional) a timeout error.
//   Saturating error statistics are kept for software and debug.
//
//   Optional feature macro: SRDL2SV_B2R_TIMEOUT_EN
//     defined   : stalled accesses are aborted after TIMEOUT_CYCLES, counted
//                 in timeout_cnt, and followed by one ST_ABORT gap cycle.
//     undefined : ST_WAIT waits for rdy or a vld drop forever; timeout_cnt=0.
//
//   Ports
//     HCLK, HRESET   clock, synchronous active-high reset
//     b2r / r2b      request from / response to the bus widget
//     b2r_o / r2b_i  per-region request / response
//     status_clr     clears unmapped_cnt, timeout_cnt, last_err_addr
//     unmapped_cnt   saturating count of unmapped accesses
//     timeout_cnt    saturating count of timed-out accesses
//     last_err_addr  b2r.addr of the most recent errored access

package srdl2sv_b2r_pkg;
    localparam int B2R_BUS_BITS = 32;

    typedef struct packed {
        logic                        w_vld;
        logic                        r_vld;
        logic [31:0]                 addr;
        logic [B2R_BUS_BITS-1:0]     data;
        logic [B2R_BUS_BITS/8-1:0]   byte_en;
    } b2r_t;

    typedef struct packed {
        logic [B2R_BUS_BITS-1:0]     data;
        logic                        rdy;
        logic                        err;
    } r2b_t;

    // Region k at k<<12; callers truncate to the regions they use.
    function automatic logic [15:0][31:0] region_base_dflt();
        logic [15:0][31:0] r;
        for (int k = 0; k < 16; k++) r[k] = 32'(k) << 12;
        return r;
    endfunction
endpackage

module srdl2sv_b2r_decoder
    import srdl2sv_b2r_pkg::*;
#(
    parameter int                          BUS_BITS       = 32,
    parameter int                          N_REGIONS      = 4,
    parameter logic [N_REGIONS-1:0][31:0]  REGION_BASE    = (N_REGIONS*32)'(region_base_dflt()),
    parameter logic [N_REGIONS-1:0][31:0]  REGION_MASK    = {N_REGIONS{32'hFFFF_F000}},
    parameter int                          TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  b2r_t        b2r,
    output r2b_t        r2b,
    output b2r_t        b2r_o [N_REGIONS],
    input  r2b_t        r2b_i [N_REGIONS],
    input  logic        status_clr,
    output logic [15:0] unmapped_cnt,
    output logic [15:0] timeout_cnt,
    output logic [31:0] last_err_addr
);

    localparam int SW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ABORT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d, hit_idx, fwd_idx;
    logic            hit_any, vld, fwd_en;
    logic            unm_ev, tmo_ev, err_ev;
    r2b_t            rsp;
    logic [BUS_BITS-1:0] rdata;

`ifdef SRDL2SV_B2R_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   cyc_q, cyc_d;
`endif

    assign vld = b2r.w_vld | b2r.r_vld;

    // Walk downwards so the lowest matching region wins on overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = N_REGIONS - 1; k >= 0; k--) begin
            if ((b2r.addr & REGION_MASK[k]) == REGION_BASE[k]) begin
                hit_any = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fwd_en  = 1'b0;
        fwd_idx = sel_q;
        rsp     = '0;
        unm_ev  = 1'b0;
        tmo_ev  = 1'b0;
        err_ev  = 1'b0;
`ifdef SRDL2SV_B2R_TIMEOUT_EN
        cyc_d   = cyc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (vld) begin
                    if (!hit_any) begin
                        rsp.rdy = 1'b1;
                        rsp.err = 1'b1;
                        unm_ev  = 1'b1;
                    end else begin
                        fwd_en  = 1'b1;
                        fwd_idx = hit_idx;
                        rsp     = r2b_i[hit_idx];
                        if (r2b_i[hit_idx].rdy) begin
                            err_ev = r2b_i[hit_idx].err;
                        end else begin
                            state_d = ST_WAIT;
                            sel_d   = hit_idx;
`ifdef SRDL2SV_B2R_TIMEOUT_EN
                            cyc_d   = CW'(1);
`endif
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Decode is frozen on sel_q; a vld drop abandons silently.
                if (!vld) begin
                    state_d = ST_IDLE;
`ifdef SRDL2SV_B2R_TIMEOUT_EN
                    cyc_d   = '0;
`endif
                end
`ifdef SRDL2SV_B2R_TIMEOUT_EN
                // A region rdy in the timeout cycle still completes normally.
                else if (cyc_q == CW'(TIMEOUT_CYCLES) && !r2b_i[sel_q].rdy) begin
                    rsp.rdy = 1'b1;
                    rsp.err = 1'b1;
                    tmo_ev  = 1'b1;
                    state_d = ST_ABORT;
                    cyc_d   = '0;
                end
`endif
                else begin
                    fwd_en = 1'b1;
                    rsp    = r2b_i[sel_q];
                    if (r2b_i[sel_q].rdy) begin
                        state_d = ST_IDLE;
                        err_ev  = r2b_i[sel_q].err;
`ifdef SRDL2SV_B2R_TIMEOUT_EN
                        cyc_d   = '0;
`endif
                    end
`ifdef SRDL2SV_B2R_TIMEOUT_EN
                    else begin
                        cyc_d = cyc_q + CW'(1);
                    end
`endif
                end
            end
            // One dead cycle so the aborted region sees vld low.
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (HRESET) begin
            fwd_en = 1'b0;
            rsp    = '0;
        end
        if (rsp.err || !rsp.rdy) rsp.data = '0;
    end

    for (genvar k = 0; k < N_REGIONS; k++) begin : g_reg
        always_comb begin
            b2r_o[k]       = b2r;
            b2r_o[k].w_vld = b2r.w_vld & fwd_en & (fwd_idx == SW'(k));
            b2r_o[k].r_vld = b2r.r_vld & fwd_en & (fwd_idx == SW'(k));
        end
    end

    assign rdata = rsp.data;
    assign r2b   = '{data: rdata, rdy: rsp.rdy, err: rsp.err};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            unmapped_cnt  <= '0;
            last_err_addr <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            // Clear takes effect first, so a coincident event counts as 1.
            if (status_clr)
                unmapped_cnt <= {15'd0, unm_ev};
            else if (unm_ev && unmapped_cnt != 16'hFFFF)
                unmapped_cnt <= unmapped_cnt + 16'd1;
            if (unm_ev || tmo_ev || err_ev)
                last_err_addr <= b2r.addr;
            else if (status_clr)
                last_err_addr <= '0;
        end
    end

`ifdef SRDL2SV_B2R_TIMEOUT_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cyc_q       <= '0;
            timeout_cnt <= '0;
        end else begin
            cyc_q <= cyc_d;
            if (status_clr)
                timeout_cnt <= {15'd0, tmo_ev};
            else if (tmo_ev && timeout_cnt != 16'hFFFF)
                timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`else
    assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_srdl2sv_b2r_decoder.sv
// Bench for srdl2sv_b2r_decoder: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_srdl2sv_b2r_decoder;
    import srdl2sv_b2r_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 4;
`ifdef SRDL2SV_B2R_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    b2r_t        b2r;
    r2b_t        r2b;
    b2r_t        b2r_o [N];
    r2b_t        r2b_i [N];
    logic        status_clr;
    logic [15:0] unmapped_cnt, timeout_cnt;
    logic [31:0] last_err_addr;

    srdl2sv_b2r_decoder #(.N_REGIONS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .b2r(b2r), .r2b(r2b),
        .b2r_o(b2r_o), .r2b_i(r2b_i), .status_clr(status_clr),
        .unmapped_cnt(unmapped_cnt), .timeout_cnt(timeout_cnt),
        .last_err_addr(last_err_addr));

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;
    int tick  = 0;

    // Reference model: pending region (-1 = none), its age in cycles,
    // and a flag for the dead cycle that follows a timeout.
    int          pend = -1;
    int          age  = 0;
    bit          gap  = 0;
    logic [15:0] m_unm = 0, m_tmo = 0;
    logic [31:0] m_lea = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic req(logic w, logic r, logic [31:0] a);
        b2r.w_vld   = w;
        b2r.r_vld   = r;
        b2r.addr    = a;
        b2r.data    = $urandom;
        b2r.byte_en = 4'($urandom);
    endtask

    task automatic rsp(int k, logic rdy, logic err, logic [31:0] d);
        r2b_i[k] = '{data: d, rdy: rdy, err: err};
    endtask

    task automatic rsp_none();
        for (int k = 0; k < N; k++) r2b_i[k] = '{data: $urandom, rdy: 1'b0, err: 1'b0};
    endtask

    // Evaluate one cycle: compare outputs, then advance DUT and model.
    task automatic step();
        int          region, fwd, np, na;
        bit          ng, unm_ev, tmo_ev, lea_ev, v;
        logic        e_rdy, e_err;
        logic [31:0] e_data;
        logic [7:0]  e_vld, a_vld;
        int          pk;
        #1;
        v      = b2r.w_vld | b2r.r_vld;
        region = (b2r.addr >> 12) < N ? int'(b2r.addr >> 12) : -1;
        fwd = -1; e_rdy = 0; e_err = 0; e_data = 0;
        np = pend; na = age; ng = 0;
        unm_ev = 0; tmo_ev = 0; lea_ev = 0;
        if (!HRESET) begin
            if (gap) begin
                ng = 0;
            end else if (pend < 0) begin
                if (v && region < 0) begin
                    e_rdy = 1; e_err = 1; unm_ev = 1; lea_ev = 1;
                end else if (v) begin
                    fwd = region;
                    e_rdy = r2b_i[region].rdy; e_err = r2b_i[region].err;
                    e_data = r2b_i[region].data;
                    if (e_rdy) lea_ev = e_err;
                    else begin np = region; na = 1; end
                end
            end else begin
                if (!v) begin
                    np = -1;
                end else if (TMO_EN && age == TMO && !r2b_i[pend].rdy) begin
                    e_rdy = 1; e_err = 1; tmo_ev = 1; lea_ev = 1; np = -1; ng = 1;
                end else begin
                    fwd = pend;
                    e_rdy = r2b_i[pend].rdy; e_err = r2b_i[pend].err;
                    e_data = r2b_i[pend].data;
                    if (e_rdy) begin np = -1; lea_ev = e_err; end
                    else na = age + 1;
                end
            end
        end
        if (e_err || !e_rdy) e_data = 0;
        for (int k = 0; k < N; k++) begin
            e_vld[2*k +: 2] = {b2r.w_vld & (fwd == k), b2r.r_vld & (fwd == k)};
            a_vld[2*k +: 2] = {b2r_o[k].w_vld, b2r_o[k].r_vld};
        end
        pk = tick % N;
        chk("region_vld", a_vld, e_vld);
        chk("rsp", {r2b.rdy, r2b.err, r2b.data}, {e_rdy, e_err, e_data});
        chk("pass_thru", {b2r_o[pk].addr, b2r_o[pk].data}, {b2r.addr, b2r.data});
        chk("cnts", {unmapped_cnt, timeout_cnt}, {m_unm, m_tmo});
        chk("last_err_addr", last_err_addr, m_lea);
        @(posedge HCLK);
        if (HRESET) begin
            pend = -1; age = 0; gap = 0; m_unm = 0; m_tmo = 0; m_lea = 0;
        end else begin
            pend = np; age = na; gap = ng;
            if (status_clr) begin m_unm = 0; m_tmo = 0; m_lea = 0; end
            if (unm_ev && m_unm != 16'hFFFF) m_unm++;
            if (tmo_ev && m_tmo != 16'hFFFF) m_tmo++;
            if (lea_ev) m_lea = b2r.addr;
        end
        tick++;
        @(negedge HCLK);
    endtask

    initial begin
        HRESET = 1; status_clr = 0;
        req(1, 0, 32'h0000_1000);
        rsp_none();
        rsp(1, 1, 0, 32'h1234_5678);
        @(negedge HCLK);
        step();
        step();
        chk("rst_cnt", {unmapped_cnt, timeout_cnt}, 32'h0);
        chk("rst_lea", last_err_addr, 32'h0);
        HRESET = 0;

        // Same-cycle read hit on region 1.
        req(0, 1, 32'h0000_1004);
        rsp_none();
        rsp(1, 1, 0, 32'hA5A5_0001);
        #1;
        chk("t1_data", {r2b.rdy, r2b.err, r2b.data}, {2'b10, 32'hA5A5_0001});
        chk("t1_rvld1", b2r_o[1].r_vld, 1'b1);
        step();

        // Unmapped write.
        req(1, 0, 32'h0000_8000);
        rsp_none();
        #1;
        chk("t2_rsp", {r2b.rdy, r2b.err, r2b.data}, {2'b11, 32'h0});
        step();
        chk("t2_cnt", unmapped_cnt, 16'd1);
        chk("t2_lea", last_err_addr, 32'h0000_8000);

        // Region 2 with three wait cycles, then back-to-back region 0.
        req(0, 1, 32'h0000_2010);
        for (int c = 0; c < 3; c++) begin
            rsp_none();
            #1;
            chk("t3_wait", r2b.rdy, 1'b0);
            step();
        end
        rsp(2, 1, 0, 32'hCAFE_0002);
        #1;
        chk("t3_done", {r2b.rdy, r2b.data}, {1'b1, 32'hCAFE_0002});
        step();
        req(0, 1, 32'h0000_0020);
        rsp_none();
        rsp(0, 1, 0, 32'h0000_BEEF);
        #1;
        chk("t3_b2b", {r2b.rdy, r2b.data}, {1'b1, 32'h0000_BEEF});
        step();

        // Region error response updates last_err_addr.
        req(0, 1, 32'h0000_1ABC);
        rsp_none();
        rsp(1, 1, 1, 32'h5555_5555);
        step();
        chk("t5_lea", last_err_addr, 32'h0000_1ABC);

`ifdef SRDL2SV_B2R_TIMEOUT_EN
        // Region 3 never ready: timeout at cycle 4, abort gap at cycle 5.
        req(1, 0, 32'h0000_3000);
        rsp_none();
        for (int c = 0; c < 4; c++) step();
        #1;
        chk("t4_tmo_rsp", {r2b.rdy, r2b.err}, 2'b11);
        chk("t4_tmo_wvld", b2r_o[3].w_vld, 1'b0);
        step();
        #1;
        chk("t4_abort", {b2r_o[3].w_vld, r2b.rdy}, 2'b00);
        step();
        chk("t4_cnt", timeout_cnt, 16'd1);
        req(0, 0, 32'h0);
        step();
        // Same again, but region answers in the timeout cycle.
        req(1, 0, 32'h0000_3004);
        for (int c = 0; c < 4; c++) step();
        rsp(3, 1, 0, 32'h0);
        #1;
        chk("t4_late_ok", {r2b.rdy, r2b.err}, 2'b10);
        step();
        chk("t4_cnt_same", timeout_cnt, 16'd1);
`else
        // Without timeout the access just waits until vld drops.
        req(1, 0, 32'h0000_3000);
        rsp_none();
        for (int c = 0; c < 12; c++) step();
        req(0, 0, 32'h0);
        step();
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 5);
            a = (sel == 5) ? $urandom : ((32'(sel) << 12) | 32'($urandom_range(0, 4095)));
            case ($urandom_range(0, 3))
                0:       req(0, 0, a);
                1:       req(1, 0, a);
                default: req(0, 1, a);
            endcase
            for (int k = 0; k < N; k++)
                rsp(k, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom);
            status_clr = ($urandom_range(0, 99) < 3);
            HRESET     = ($urandom_range(0, 99) == 0);
            step();
        end
        status_clr = 0; HRESET = 0;
        req(0, 0, 32'h0); rsp_none();
        step(); step();

        // Saturation of unmapped_cnt, then clear coincident with an event.
        status_clr = 1;
        step();
        status_clr = 0;
        for (int i = 0; i < 65535; i++) begin
            req(1, 0, 32'h8000_0000 | 32'(i));
            step();
        end
        chk("sat_full", unmapped_cnt, 16'hFFFF);
        req(0, 1, 32'hFFFF_0000);
        step();
        chk("sat_hold", unmapped_cnt, 16'hFFFF);
        status_clr = 1;
        req(1, 0, 32'h0001_2340);
        step();
        status_clr = 0;
        chk("clr_evt_cnt", unmapped_cnt, 16'd1);
        chk("clr_evt_lea", last_err_addr, 32'h0001_2340);

        // Reset while waiting, then a fresh read completes normally.
        req(0, 1, 32'h0000_0100);
        rsp_none();
        step(); step();
        HRESET = 1;
        step();
        HRESET = 0;
        #1;
        chk("rst_wait_cnt", {unmapped_cnt, timeout_cnt, last_err_addr}, 64'h0);
        rsp(0, 1, 0, 32'h0BAD_F00D);
        #1;
        chk("rst_wait_fresh", {r2b.rdy, r2b.err, r2b.data}, {2'b10, 32'h0BAD_F00D});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
